// File: rtl/tt_channel_bank.sv
// tt_channel_bank: per-channel write buffers copied to time-triggered output registers on matching global-time ticks
module tt_channel_bank #(
    parameter int NCH = 8,
    parameter int DW  = 32,
    parameter int TW  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TW-1:0]          g_time,
    input  logic                   wr_en,
    input  logic [$clog2(NCH)+2:0] waddr,
    input  logic [DW-1:0]          wdata,
    input  logic                   rd_en,
    input  logic [$clog2(NCH)+2:0] raddr,
    output logic [DW-1:0]          rdata,
    output logic                   rvalid,
    output logic [NCH-1:0]         trig,
    output logic                   ovr_irq
);
    localparam int AW = $clog2(NCH) + 3;
    logic [DW-1:0]  buf_q [NCH];
    logic [DW-1:0]  ph    [NCH];
    logic [DW-1:0]  out   [NCH];
    logic [TW-1:0]  mask  [NCH];
    logic [TW-1:0]  g_prev;
    logic [TW-1:0]  wmask;
    logic [NCH-1:0] en, os, pend, ovr, fire, wsel;
    logic [DW-1:0]  rval;
    logic [2:0]     wf, rf;
    logic           tick;
    assign tick    = g_time != g_prev;
    assign wf      = waddr[2:0];
    assign rf      = raddr[2:0];
    assign ovr_irq = |ovr;
    // exponents at or beyond the time width compare every bit
    assign wmask = (int'(wdata[4:0]) >= TW) ? '1 : ~({TW{1'b1}} << wdata[4:0]);
    always_comb begin
        fire = '0;
        wsel = '0;
        for (int i = 0; i < NCH; i++) begin
            wsel[i] = wr_en && ((waddr >> 3) == AW'(i));
            fire[i] = tick && en[i] && ((g_time & mask[i]) == (TW'(ph[i]) & mask[i])) && (!os[i] || pend[i]);
        end
    end
    always_comb begin
        rval = '0;
        for (int i = 0; i < NCH; i++)
            if ((raddr >> 3) == AW'(i))
                rval = rf == 3'd0 ? buf_q[i] :
                       rf == 3'd1 ? DW'(mask[i]) :
                       rf == 3'd2 ? ph[i] :
                       rf == 3'd3 ? DW'({os[i], en[i]}) :
                       rf == 3'd4 ? out[i] :
                       rf == 3'd5 ? DW'({ovr[i], pend[i]}) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            g_prev <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            trig   <= '0;
            en     <= '0;
            os     <= '0;
            pend   <= '0;
            ovr    <= '0;
            for (int i = 0; i < NCH; i++) begin
                buf_q[i] <= '0;
                ph[i]    <= '0;
                out[i]   <= '0;
                mask[i]  <= '0;
            end
        end else begin
            g_prev <= g_time;
            rvalid <= rd_en;
            trig   <= fire;
            if (rd_en)
                rdata <= rval;
            for (int i = 0; i < NCH; i++) begin
                if (fire[i]) begin
                    out[i]  <= buf_q[i];
                    pend[i] <= 1'b0;
                end
                // a buffer write lands after the copy, so the copy sees the old buffer
                if (wsel[i])
                    case (wf)
                        3'd0: begin
                            buf_q[i] <= wdata;
                            pend[i]  <= 1'b1;
                            if (pend[i] && !fire[i])
                                ovr[i] <= 1'b1;
                        end
                        3'd1: mask[i] <= wmask;
                        3'd2: ph[i] <= wdata;
                        3'd3: begin
                            en[i] <= wdata[0];
                            os[i] <= wdata[1];
                        end
                        3'd5: if (wdata[1]) ovr[i] <= 1'b0;
                        default: ;
                    endcase
            end
        end
    end
endmodule
